// File: rtl/pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_sequencer: program counter, next-PC select, flush window, halt/trap.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        halted,
  output logic        misalign,
  output logic [15:0] redirect_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [2:0] c_cnt_init = 3'(FLUSH_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic        r_halt_pending, w_halt_pending_nxt;
  logic        r_misalign, w_misalign_nxt;
  logic [15:0] r_redirect_cnt, w_redirect_cnt_nxt;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_redirect;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_redirect = (pc_sel == 2'd1) || (pc_sel == 2'd2);
  assign w_target   = (pc_sel == 2'd2) ? (jump_target & ~32'h1) : branch_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_pc           <= RESET_PC;
      r_cnt          <= 3'd0;
      r_halt_pending <= 1'b0;
      r_misalign     <= 1'b0;
      r_redirect_cnt <= 16'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_cnt          <= w_cnt_nxt;
      r_halt_pending <= w_halt_pending_nxt;
      r_misalign     <= w_misalign_nxt;
      r_redirect_cnt <= w_redirect_cnt_nxt;
    end
  end

  // Defaults equal the held values, so a stall simply skips the case below.
  always_comb begin
    w_state_nxt        = r_state;
    w_pc_nxt           = r_pc;
    w_cnt_nxt          = r_cnt;
    w_halt_pending_nxt = r_halt_pending;
    w_misalign_nxt     = 1'b0;
    w_redirect_cnt_nxt = r_redirect_cnt;
    if (!stall) begin
      case (r_state)
        ST_RUN: begin
          if (w_redirect) begin
            w_state_nxt = ST_FLUSH;
            w_cnt_nxt   = c_cnt_init;
            if (halt_req) w_halt_pending_nxt = 1'b1;
            if (w_target[1:0] == 2'b00) begin
              w_pc_nxt = w_target;
              if (r_redirect_cnt != 16'hFFFF) w_redirect_cnt_nxt = r_redirect_cnt + 16'd1;
            end else begin
              w_pc_nxt       = TRAP_VEC;
              w_misalign_nxt = 1'b1;
            end
          end else if (halt_req) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_pc_nxt = w_pc_plus4;
          end
        end
        ST_FLUSH: begin
          w_pc_nxt = w_pc_plus4;
          if (r_cnt == 3'd0) begin
            if (r_halt_pending || halt_req) begin
              w_state_nxt        = ST_HALT;
              w_halt_pending_nxt = 1'b0;
            end else begin
              w_state_nxt = ST_RUN;
            end
          end else begin
            w_cnt_nxt = r_cnt - 3'd1;
            if (halt_req) w_halt_pending_nxt = 1'b1;
          end
        end
        ST_HALT: begin
          if (resume) w_state_nxt = ST_RUN;
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  assign pc           = r_pc;
  assign pc_plus4     = w_pc_plus4;
  assign flush        = (r_state == ST_FLUSH);
  assign halted       = (r_state == ST_HALT);
  assign misalign     = r_misalign & ~stall;
  assign redirect_cnt = r_redirect_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pc_sequencer: directed scenarios plus randomized run vs. a model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC     = 32'h0000_0100;
  localparam int          FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  pc_sel = 2'd0;
  logic [31:0] branch_target = 32'd0;
  logic [31:0] jump_target = 32'd0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] pc, pc_plus4;
  logic        flush, halted, misalign;
  logic [15:0] redirect_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: flush expressed as "cycles of flush remaining".
  logic [31:0] m_pc = RESET_PC;
  int          m_flush_left = 0;
  bit          m_halted = 0;
  bit          m_hp = 0;
  bit          m_mis = 0;
  int          m_rc = 0;

  pc_sequencer #(
    .RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_sel(pc_sel),
    .branch_target(branch_target), .jump_target(jump_target),
    .halt_req(halt_req), .resume(resume), .pc(pc), .pc_plus4(pc_plus4),
    .flush(flush), .halted(halted), .misalign(misalign), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    logic [31:0] tgt;
    if (rst) begin
      m_pc = RESET_PC; m_flush_left = 0; m_halted = 0; m_hp = 0; m_mis = 0; m_rc = 0;
    end else if (stall) begin
      m_mis = 0;
    end else begin
      m_mis = 0;
      if (m_halted) begin
        if (resume) m_halted = 0;
      end else if (m_flush_left > 0) begin
        m_pc = m_pc + 32'd4;
        if (halt_req) m_hp = 1;
        m_flush_left--;
        if (m_flush_left == 0 && m_hp) begin
          m_halted = 1; m_hp = 0;
        end
      end else if (pc_sel == 2'd1 || pc_sel == 2'd2) begin
        tgt = (pc_sel == 2'd1) ? branch_target : {jump_target[31:1], 1'b0};
        if (tgt % 4 == 0) begin
          m_pc = tgt;
          if (m_rc < 65535) m_rc++;
        end else begin
          m_pc = TRAP_VEC; m_mis = 1;
        end
        m_flush_left = FLUSH_CYCLES;
        if (halt_req) m_hp = 1;
      end else if (halt_req) begin
        m_halted = 1;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic do_cycle(input logic r, input logic s, input logic [1:0] sel,
                          input logic [31:0] bt, input logic [31:0] jt,
                          input logic h, input logic rs);
    @(negedge clk);
    rst = r; stall = s; pc_sel = sel; branch_target = bt; jump_target = jt;
    halt_req = h; resume = rs;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    do_cycle(1, 0, 2'd0, 0, 0, 0, 0);
    do_cycle(1, 0, 2'd0, 0, 0, 0, 0);
    n_checks++; if (pc !== RESET_PC) begin n_errors++; $display("FAIL reset_pc: got %h expected %h", pc, RESET_PC); end
    n_checks++; if (pc_plus4 !== RESET_PC + 32'd4) begin n_errors++; $display("FAIL reset_pc_plus4: got %h expected %h", pc_plus4, RESET_PC + 32'd4); end
    n_checks++; if ({flush, halted, misalign} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b expected 000", {flush, halted, misalign}); end
    n_checks++; if (redirect_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_redirect_cnt: got %0d expected 0", redirect_cnt); end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      do_cycle(0, 0, (i == 2) ? 2'd3 : 2'd0, 32'h44, 32'h88, 0, 0);
      n_checks++; if (pc !== 32'(4 * i) || flush !== 1'b0) begin n_errors++; $display("FAIL seq_pc%0d: got pc=%h flush=%b expected pc=%h flush=0", i, pc, flush, 32'(4 * i)); end
    end
  endtask

  task automatic test_branch();
    do_cycle(0, 0, 2'd1, 32'h40, 32'h0, 0, 0);
    n_checks++; if (pc !== 32'h40 || flush !== 1'b1 || redirect_cnt !== 16'd1) begin n_errors++; $display("FAIL branch_take: got pc=%h flush=%b cnt=%0d expected pc=40 flush=1 cnt=1", pc, flush, redirect_cnt); end
    do_cycle(0, 0, 2'd2, 32'h0, 32'h500, 0, 0);
    n_checks++; if (pc !== 32'h44 || flush !== 1'b1 || redirect_cnt !== 16'd1) begin n_errors++; $display("FAIL branch_flush2: got pc=%h flush=%b cnt=%0d expected pc=44 flush=1 cnt=1", pc, flush, redirect_cnt); end
    do_cycle(0, 0, 2'd0, 32'h0, 32'h0, 0, 0);
    n_checks++; if (pc !== 32'h48 || flush !== 1'b0) begin n_errors++; $display("FAIL branch_end: got pc=%h flush=%b expected pc=48 flush=0", pc, flush); end
  endtask

  task automatic test_jump_misalign();
    do_cycle(0, 0, 2'd2, 32'h0, 32'h81, 0, 0);
    n_checks++; if (pc !== 32'h80 || misalign !== 1'b0 || redirect_cnt !== 16'd2) begin n_errors++; $display("FAIL jump_bit0: got pc=%h mis=%b cnt=%0d expected pc=80 mis=0 cnt=2", pc, misalign, redirect_cnt); end
    do_cycle(0, 0, 2'd0, 0, 0, 0, 0);
    do_cycle(0, 0, 2'd0, 0, 0, 0, 0);
    do_cycle(0, 0, 2'd1, 32'h102, 32'h0, 0, 0);
    n_checks++; if (pc !== TRAP_VEC || misalign !== 1'b1 || flush !== 1'b1 || redirect_cnt !== 16'd2) begin n_errors++; $display("FAIL misalign_trap: got pc=%h mis=%b flush=%b cnt=%0d expected pc=100 mis=1 flush=1 cnt=2", pc, misalign, flush, redirect_cnt); end
    do_cycle(0, 0, 2'd0, 0, 0, 0, 0);
    n_checks++; if (pc !== 32'h104 || misalign !== 1'b0) begin n_errors++; $display("FAIL misalign_pulse: got pc=%h mis=%b expected pc=104 mis=0", pc, misalign); end
    do_cycle(0, 0, 2'd0, 0, 0, 0, 0);
  endtask

  task automatic test_stall();
    do_cycle(0, 0, 2'd1, 32'h40, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      do_cycle(0, 1, 2'd2, 32'h0, 32'h800, 0, 0);
      n_checks++; if (pc !== 32'h40 || flush !== 1'b1 || pc_plus4 !== 32'h44) begin n_errors++; $display("FAIL stall_hold%0d: got pc=%h flush=%b p4=%h expected pc=40 flush=1 p4=44", i, pc, flush, pc_plus4); end
    end
    do_cycle(0, 0, 2'd0, 0, 0, 0, 0);
    n_checks++; if (pc !== 32'h44 || flush !== 1'b1) begin n_errors++; $display("FAIL stall_release: got pc=%h flush=%b expected pc=44 flush=1", pc, flush); end
    do_cycle(0, 0, 2'd0, 0, 0, 0, 0);
    n_checks++; if (pc !== 32'h48 || flush !== 1'b0) begin n_errors++; $display("FAIL stall_end: got pc=%h flush=%b expected pc=48 flush=0", pc, flush); end
  endtask

  task automatic test_halt();
    logic [31:0] exp_pc [6] = '{32'h200, 32'h204, 32'h208, 32'h208, 32'h208, 32'h20C};
    logic [1:0]  exp_fh [6] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00};
    logic        hreq   [6] = '{1, 0, 0, 0, 1, 0};
    logic        res    [6] = '{0, 0, 0, 0, 1, 0};
    logic [1:0]  sel    [6] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
    for (int i = 0; i < 6; i++) begin
      do_cycle(0, 0, sel[i], (i == 0) ? 32'h200 : 32'h300, 32'h0, hreq[i], res[i]);
      n_checks++; if (pc !== exp_pc[i] || {flush, halted} !== exp_fh[i]) begin n_errors++; $display("FAIL halt_step%0d: got pc=%h flush/halted=%b expected pc=%h flush/halted=%b", i, pc, {flush, halted}, exp_pc[i], exp_fh[i]); end
    end
    do_cycle(0, 0, 2'd0, 0, 0, 1, 0);
    n_checks++; if (pc !== 32'h20C || halted !== 1'b1) begin n_errors++; $display("FAIL halt_plain: got pc=%h halted=%b expected pc=20c halted=1", pc, halted); end
    do_cycle(1, 0, 2'd0, 0, 0, 0, 0);
    n_checks++; if (pc !== RESET_PC || halted !== 1'b0 || redirect_cnt !== 16'd0) begin n_errors++; $display("FAIL halt_reset: got pc=%h halted=%b cnt=%0d expected pc=%h halted=0 cnt=0", pc, halted, redirect_cnt, RESET_PC); end
  endtask

  task automatic test_wrap();
    do_cycle(0, 0, 2'd2, 32'h0, 32'hFFFF_FFF8, 0, 0);
    do_cycle(0, 0, 2'd0, 0, 0, 0, 0);
    n_checks++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin n_errors++; $display("FAIL wrap_top: got pc=%h p4=%h expected pc=fffffffc p4=0", pc, pc_plus4); end
    do_cycle(0, 0, 2'd0, 0, 0, 0, 0);
    n_checks++; if (pc !== 32'h0 || flush !== 1'b0) begin n_errors++; $display("FAIL wrap_zero: got pc=%h flush=%b expected pc=0 flush=0", pc, flush); end
    do_cycle(0, 0, 2'd0, 0, 0, 0, 0);
    n_checks++; if (pc !== 32'h4) begin n_errors++; $display("FAIL wrap_next: got pc=%h expected pc=4", pc); end
  endtask

  task automatic test_random();
    logic [31:0] bt, jt;
    do_cycle(1, 0, 2'd0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      bt = $urandom; jt = $urandom;
      if ($urandom_range(3) != 0) bt[1:0] = 2'b00;
      if ($urandom_range(3) != 0) jt[1] = 1'b0;
      do_cycle(($urandom_range(59) == 0), ($urandom_range(4) == 0), 2'($urandom_range(3)),
               bt, jt, ($urandom_range(7) == 0), ($urandom_range(2) == 0));
      n_checks++; if (pc !== m_pc) begin n_errors++; $display("FAIL rand_pc@%0d: got %h expected %h", i, pc, m_pc); end
      n_checks++; if (pc_plus4 !== m_pc + 32'd4) begin n_errors++; $display("FAIL rand_pc_plus4@%0d: got %h expected %h", i, pc_plus4, m_pc + 32'd4); end
      n_checks++; if (flush !== (m_flush_left > 0)) begin n_errors++; $display("FAIL rand_flush@%0d: got %b expected %b", i, flush, (m_flush_left > 0)); end
      n_checks++; if (halted !== m_halted) begin n_errors++; $display("FAIL rand_halted@%0d: got %b expected %b", i, halted, m_halted); end
      n_checks++; if (misalign !== (m_mis && !stall)) begin n_errors++; $display("FAIL rand_misalign@%0d: got %b expected %b", i, misalign, (m_mis && !stall)); end
      n_checks++; if (redirect_cnt !== 16'(m_rc)) begin n_errors++; $display("FAIL rand_redirect_cnt@%0d: got %0d expected %0d", i, redirect_cnt, m_rc); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump_misalign();
    test_stall();
    test_halt();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
